burst_ram_arbiter: RTL
======================

# burst_ram_arbiter

Two-client arbiter that shares one BurstRAM command/data port between requesters, e.g. the RAMIO cache and a flash-to-RAM loader. It accepts whole-burst read or write commands from either client, issues them to the BurstRAM one at a time with round-robin fairness, and forwards the write beats or read beats for exactly one burst before releasing the port. It sits between the clients' `br_*` style ports and the BurstRAM instance.

## Interface
- `DEPTH_BITWIDTH`, 9: BurstRAM address width; the address is in 8-byte words.
- `BURST_COUNT`, 4: 64-bit beats per burst; must be ≥ 2.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cN_cmd` in 1 (N = 0, 1): 0 read, 1 write.
- `cN_cmd_en` in 1: request; held high until `cN_ack`.
- `cN_addr` in DEPTH_BITWIDTH: burst address.
- `cN_wr_data` in 64: write beat.
- `cN_data_mask` in 8: forwarded unchanged.
- `cN_ack` out 1: one-cycle pulse when the command is issued to the RAM.
- `cN_rd_data` out 64: read beat, a fan-out of `br_rd_data`.
- `cN_rd_data_valid` out 1: read beat valid for this client only.
- `br_cmd`, `br_cmd_en`, `br_addr`, `br_wr_data`, `br_data_mask` out: BurstRAM command/data.
- `br_rd_data` in 64, `br_rd_data_valid` in 1, `br_busy` in 1, `br_init_calib` in 1: BurstRAM status/data.
- `stray_valid` out 1: sticky error flag; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WRITE, READ.
- **IDLE**
  - Arbitration happens when `br_init_calib && !br_busy` and at least one `cN_cmd_en` is high.
  - Single requester wins outright.
  - If both request, the winner is the client that is not `last_owner`.
  - The winner is latched into `owner` along with its cmd, addr and mask. Next state is ISSUE.
- **ISSUE** (one cycle)
  - `br_cmd_en`=1 with the latched cmd/addr/mask, and `c<owner>_ack`=1.
  - `last_owner` ← `owner`.
  - Next state: WRITE if cmd=1, else READ.
  - The beat counter is set to 1 for a write and 0 for a read.
- **Write data path**
  - `br_wr_data` is a combinational mux of `c<owner>_wr_data` during ISSUE and WRITE; otherwise it is 0.
  - The client holds beat 0 while `cmd_en` is high, so beat 0 is present in the ack cycle. It presents beat k on the k-th cycle after ack.
- **WRITE**
  - Increment the counter every cycle.
  - Return to IDLE in the cycle the counter reaches BURST_COUNT-1, after BURST_COUNT-1 cycles in WRITE.
- **READ**
  - `c<owner>_rd_data_valid` = `br_rd_data_valid`; the other client's valid is 0.
  - Count the valid beats. Go to IDLE on the cycle beat BURST_COUNT-1 is seen.
  - There is no timeout.
- `br_rd_data_valid` while in IDLE or WRITE sets `stray_valid`. The beat is not forwarded to either client.
- A client that drops `cmd_en` before its ack is treated as withdrawn. Arbitration uses only the current-cycle request.
- **Counter width:** clog2(BURST_COUNT). Wrap-around cannot occur because the state exits at BURST_COUNT-1.

## Timing
- **Reset values:**
  - state=IDLE, `last_owner`=1 (client 0 wins the first tie), counter=0.
  - All `br_*` outputs 0, `cN_ack`=0, `cN_rd_data_valid`=0, `stray_valid`=0.
- **Request latency:** request seen in IDLE at cycle T gives `br_cmd_en` and `ack` at T+1.
- **Write occupancy:** ISSUE plus BURST_COUNT-1 WRITE cycles. The earliest next ISSUE is T+BURST_COUNT+2.
- **Read occupancy:** from ISSUE until the last valid beat, plus one IDLE cycle before the next ISSUE.
- `br_cmd_en` is high for exactly one cycle per accepted command and is never high outside ISSUE.
- `br_busy` or `!br_init_calib` in IDLE stalls arbitration. It has no effect once past IDLE.
- Reset asserted mid-burst returns all state and outputs to reset values immediately (asynchronous). An in-flight burst is abandoned; later stray beats set `stray_valid` only after reset deasserts.

## Structure
- Package `burst_ram_arbiter_pkg` holds:
  - the state enum (IDLE, ISSUE, WRITE, READ);
  - the `owner_t` one-bit client index;
  - the `BR_DATA_W`=64 and `BR_MASK_W`=8 constants.
- One small sub-module, `rr_pick2`, is natural: it is combinational and takes `req[1:0]` and `last_owner` and returns `grant_valid` and `grant`. Everything else is a single FSM in the top.

## Test plan
- **Single write:** c0 write addr=0x010, beats 0xA0..0xA3.
  - `ack` one cycle after the request, `br_cmd_en` for one cycle.
  - `br_wr_data` sequence A0,A1,A2,A3 over 4 consecutive cycles.
  - Back in IDLE after 4 cycles.
- **Read routing:** c1 read addr=0x020; BurstRAM model (latency 6) returns 0xB0..0xB3.
  - `c1_rd_data_valid` high for 4 beats with B0..B3; `c0_rd_data_valid` stays 0.
- **Round-robin:** both clients request continuously from reset.
  - Grant order is 0,1,0,1; no client is acked twice in a row while the other waits.
- **Stall:** hold `br_init_calib`=0, then `br_busy`=1, with c0 requesting.
  - No `ack` and no `br_cmd_en` until both clear; `ack` follows one cycle later.
- **Reset mid-read:** assert `rst` after 2 of 4 read beats.
  - All outputs 0 immediately.
  - Remaining beats after deassert set `stray_valid`=1 and are not forwarded.
  - The next c0 write proceeds normally.

Source files
------------

// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types and constants for the two-client BurstRAM arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package burst_ram_arbiter_pkg;

   localparam int BR_DATA_W = 64;
   localparam int BR_MASK_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WRITE = 2'd2,
      READ  = 2'd3
   } state_t;

   // Index of a client port: 0 or 1.
   typedef logic owner_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the client that did not own the port last wins.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is taken.
module rr_pick2
   import burst_ram_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last_owner,
   output logic       grant_valid,
   output owner_t     grant
);

   // Single requester wins outright; a tie goes to the client that waited.
   always_comb begin
      grant_valid = |req;
      grant       = 1'b0;
      case (req)
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_owner;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one BurstRAM command/data port between two clients, one whole burst at a time.
// Latency: request seen in IDLE at cycle T gives br_cmd_en and ack at T+1.
// Backpressure: br_busy or !br_init_calib stall arbitration in IDLE only; clients hold cmd_en until ack.
module burst_ram_arbiter
   import burst_ram_arbiter_pkg::*;
#(
   parameter int DEPTH_BITWIDTH = 9,
   parameter int BURST_COUNT    = 4
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      c0_cmd,
   input  logic                      c0_cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0] c0_addr,
   input  logic [BR_DATA_W-1:0]      c0_wr_data,
   input  logic [BR_MASK_W-1:0]      c0_data_mask,
   output logic                      c0_ack,
   output logic [BR_DATA_W-1:0]      c0_rd_data,
   output logic                      c0_rd_data_valid,
   input  logic                      c1_cmd,
   input  logic                      c1_cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0] c1_addr,
   input  logic [BR_DATA_W-1:0]      c1_wr_data,
   input  logic [BR_MASK_W-1:0]      c1_data_mask,
   output logic                      c1_ack,
   output logic [BR_DATA_W-1:0]      c1_rd_data,
   output logic                      c1_rd_data_valid,
   output logic                      br_cmd,
   output logic                      br_cmd_en,
   output logic [DEPTH_BITWIDTH-1:0] br_addr,
   output logic [BR_DATA_W-1:0]      br_wr_data,
   output logic [BR_MASK_W-1:0]      br_data_mask,
   input  logic [BR_DATA_W-1:0]      br_rd_data,
   input  logic                      br_rd_data_valid,
   input  logic                      br_busy,
   input  logic                      br_init_calib,
   output logic                      stray_valid
);

   localparam int CW = $clog2(BURST_COUNT);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);

   state_t        state;
   owner_t        owner;
   owner_t        last_owner;
   logic [CW-1:0] beat_cnt;
   logic          grant_valid;
   owner_t        grant;

   rr_pick2 u_pick (
      .req         ({c1_cmd_en, c0_cmd_en}),
      .last_owner  (last_owner),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // Main FSM: arbitrate, issue one command, then hold the port for exactly one burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         owner        <= 1'b0;
         last_owner   <= 1'b1;
         beat_cnt     <= '0;
         br_cmd       <= 1'b0;
         br_cmd_en    <= 1'b0;
         br_addr      <= '0;
         br_data_mask <= '0;
         c0_ack       <= 1'b0;
         c1_ack       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (br_init_calib && !br_busy && grant_valid) begin
                  owner        <= grant;
                  br_cmd       <= grant ? c1_cmd       : c0_cmd;
                  br_addr      <= grant ? c1_addr      : c0_addr;
                  br_data_mask <= grant ? c1_data_mask : c0_data_mask;
                  br_cmd_en    <= 1'b1;
                  c0_ack       <= ~grant;
                  c1_ack       <= grant;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               br_cmd_en  <= 1'b0;
               c0_ack     <= 1'b0;
               c1_ack     <= 1'b0;
               last_owner <= owner;
               // Beat 0 of a write goes out in this cycle, so the write count starts at 1.
               beat_cnt   <= br_cmd ? CW'(1) : '0;
               state      <= br_cmd ? WRITE : READ;
            end
            WRITE: begin
               if (beat_cnt == LAST_BEAT) state <= IDLE;
               else                       beat_cnt <= beat_cnt + CW'(1);
            end
            READ: begin
               if (br_rd_data_valid) begin
                  if (beat_cnt == LAST_BEAT) state <= IDLE;
                  else                       beat_cnt <= beat_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky flag for read beats arriving when no read burst owns the port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                   stray_valid <= 1'b0;
      else if (br_rd_data_valid && (state == IDLE || state == WRITE)) stray_valid <= 1'b1;
   end

   assign br_wr_data       = (state == ISSUE || state == WRITE) ? (owner ? c1_wr_data : c0_wr_data) : '0;
   assign c0_rd_data       = br_rd_data;
   assign c1_rd_data       = br_rd_data;
   assign c0_rd_data_valid = (state == READ) && !owner && br_rd_data_valid;
   assign c1_rd_data_valid = (state == READ) &&  owner && br_rd_data_valid;

endmodule
